cpu_convert_unit: RTL

//  Multi-cycle WebAssembly numeric conversion unit for the stack CPU: wrap, extend, reinterpret
//  (i32<->f32, i64<->f64) and float->int truncation (signed/unsigned, 32/64). Accepts one op
//  via valid/ready from the execute stage, returns a typed 64-bit result or a cpu.vh trap code.

---
 rtl/cpu_convert_unit.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_convert_unit.sv
// ============================================================================
// cpu_convert_unit
// ----------------------------------------------------------------------------
// Multi-cycle WebAssembly numeric conversion unit for the stack CPU.
// Handles i32.wrap_i64, i64.extend_i32_s/u, the four reinterpret ops
// (i32<->f32, i64<->f64) and the eight float->int truncations. One op is
// accepted through a valid/ready handshake; the result (or a trap code) is
// held on the output side until the consumer takes it.
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        synchronous, active-high
//   in_valid     op + operand presented by the execute stage
//   in_ready     unit idle and holding no result
//   in_opcode    wasm opcode 0xA7-0xB1 or 0xBC-0xBF
//   in_operand   operand bits; 32-bit operands live in [31:0]
//   out_valid    result or trap available, held until out_ready
//   out_ready    consumer takes the result
//   result       result bits; 32-bit results zero-extended
//   result_type  i32/i64/f32/f64 tag of the result
//   trap         trap code (0 = none), valid with out_valid
//
// Parameters
//   HAS_FPU      0: every float-typed op traps NO_FPU
//   USE_64B      0: any op touching an i64/f64 value traps NO_64B
//   SHIFT_STEP   mantissa shift distance per SHIFT cycle (1, 2, 4 or 8)
// ============================================================================
module cpu_convert_unit #(
    parameter bit HAS_FPU    = 1'b1,
    parameter bit USE_64B    = 1'b1,
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_opcode,
    input  logic [63:0] in_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [1:0]  result_type,
    output logic [3:0]  trap
);

    // Value-type and trap encodings shared with the rest of the CPU (cpu.vh).
    localparam logic [1:0] T_I32 = 2'd0;
    localparam logic [1:0] T_I64 = 2'd1;
    localparam logic [1:0] T_F32 = 2'd2;
    localparam logic [1:0] T_F64 = 2'd3;

    localparam logic [3:0] TRAP_NONE               = 4'd0;
    localparam logic [3:0] TRAP_INVALID_OPCODE     = 4'd1;
    localparam logic [3:0] TRAP_INTEGER_OVERFLOW   = 4'd2;
    localparam logic [3:0] TRAP_INVALID_CONVERSION = 4'd3;
    localparam logic [3:0] TRAP_NO_FPU             = 4'd4;
    localparam logic [3:0] TRAP_NO_64B             = 4'd5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [6:0] STEP = 7'(SHIFT_STEP);

    typedef struct packed {
        logic       legal;
        logic       uses_64;
        logic       uses_fpu;
        logic       is_trunc;
        logic [1:0] dst_type;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [7:0] op);
        op_info_t d;
        d = '{legal: 1'b0, uses_64: 1'b0, uses_fpu: 1'b0, is_trunc: 1'b0, dst_type: T_I32};
        case (op)
            8'hA7:               d = '{1'b1, 1'b1, 1'b0, 1'b0, T_I32};
            8'hA8, 8'hA9:        d = '{1'b1, 1'b0, 1'b1, 1'b1, T_I32};
            8'hAA, 8'hAB:        d = '{1'b1, 1'b1, 1'b1, 1'b1, T_I32};
            8'hAC, 8'hAD:        d = '{1'b1, 1'b1, 1'b0, 1'b0, T_I64};
            8'hAE, 8'hAF,
            8'hB0, 8'hB1:        d = '{1'b1, 1'b1, 1'b1, 1'b1, T_I64};
            8'hBC:               d = '{1'b1, 1'b0, 1'b1, 1'b0, T_I32};
            8'hBD:               d = '{1'b1, 1'b1, 1'b1, 1'b0, T_I64};
            8'hBE:               d = '{1'b1, 1'b0, 1'b1, 1'b0, T_F32};
            8'hBF:               d = '{1'b1, 1'b1, 1'b1, 1'b0, T_F64};
            default:             d = '{1'b0, 1'b0, 1'b0, 1'b0, T_I32};
        endcase
        return d;
    endfunction

    // Apply the sign and narrow to the destination width (i32 results are
    // zero-extended into the upper word).
    function automatic logic [63:0] finalize(input logic [63:0] mag, input logic neg,
                                             input logic wide);
        logic [63:0] v;
        v = neg ? (~mag + 64'd1) : mag;
        return wide ? v : {32'd0, v[31:0]};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]  state_q,   state_d;
    logic [63:0] result_q,  result_d;
    logic [1:0]  rtype_q,   rtype_d;
    logic [3:0]  trap_q,    trap_d;
    logic [7:0]  opcode_q,  opcode_d;
    logic [63:0] operand_q, operand_d;
    logic [3:0]  pretrap_q, pretrap_d;
    logic [1:0]  dst_q,     dst_d;
    logic [63:0] mag_q,     mag_d;
    logic [6:0]  rem_q,     rem_d;

    // ------------------------------------------------------------------------
    // Accept-time decode: structural traps resolved before any datapath work
    // ------------------------------------------------------------------------
    op_info_t   in_info;
    logic [3:0] in_pretrap;

    always_comb begin
        in_info = decode_op(in_opcode);
        if (!in_info.legal)                       in_pretrap = TRAP_INVALID_OPCODE;
        else if (in_info.uses_64  && !USE_64B)    in_pretrap = TRAP_NO_64B;
        else if (in_info.uses_fpu && !HAS_FPU)    in_pretrap = TRAP_NO_FPU;
        else                                      in_pretrap = TRAP_NONE;
    end

    // ------------------------------------------------------------------------
    // Float classification of the latched operand (used in CHECK and SHIFT)
    // ------------------------------------------------------------------------
    logic               src_f64, dst64, is_unsigned;
    logic               f_sign, exp_ones, mant_zero;
    logic [12:0]        exp_raw;
    logic signed [12:0] bias, exp_e, n_bits, m_val;
    logic [63:0]        sig;
    logic               is_nan, is_inf, is_small, is_ovf, shift_left;
    logic [6:0]         shift_cnt;

    always_comb begin
        src_f64     = (opcode_q == 8'hAA) || (opcode_q == 8'hAB) ||
                      (opcode_q == 8'hB0) || (opcode_q == 8'hB1);
        dst64       = (opcode_q >= 8'hAE);
        is_unsigned = opcode_q[0];

        if (src_f64) begin
            f_sign    = operand_q[63];
            exp_raw   = {2'b00, operand_q[62:52]};
            exp_ones  = &operand_q[62:52];
            mant_zero = (operand_q[51:0] == 52'd0);
            sig       = {11'd0, 1'b1, operand_q[51:0]};
            bias      = 13'sd1023;
            m_val     = 13'sd52;
        end else begin
            f_sign    = operand_q[31];
            exp_raw   = {5'b00000, operand_q[30:23]};
            exp_ones  = &operand_q[30:23];
            mant_zero = (operand_q[22:0] == 23'd0);
            sig       = {40'd0, 1'b1, operand_q[22:0]};
            bias      = 13'sd127;
            m_val     = 13'sd23;
        end

        exp_e    = $signed(exp_raw) - bias;
        n_bits   = dst64 ? 13'sd64 : 13'sd32;
        is_nan   = exp_ones && !mant_zero;
        is_inf   = exp_ones && mant_zero;
        is_small = (exp_e < 13'sd0);

        // Only -2^(N-1) itself survives at E == N-1 on the signed side; on
        // the unsigned side any negative value with E >= 0 is at most -1.0.
        if (is_unsigned)
            is_ovf = (exp_e >= n_bits) || f_sign;
        else
            is_ovf = (exp_e >= n_bits - 13'sd1) &&
                     !(f_sign && (exp_e == n_bits - 13'sd1) && mant_zero);

        // Meaningful only on the in-range path, where 0 <= E <= 63.
        shift_left = (exp_e > m_val);
        shift_cnt  = shift_left ? (exp_e[6:0] - m_val[6:0]) : (m_val[6:0] - exp_e[6:0]);
    end

    // ------------------------------------------------------------------------
    // Shifter: moves at most STEP bits per cycle, the last step may be short
    // ------------------------------------------------------------------------
    logic [6:0]  step;
    logic [63:0] mag_shifted;
    logic [6:0]  rem_left;

    always_comb begin
        step        = (rem_q > STEP) ? STEP : rem_q;
        mag_shifted = shift_left ? (mag_q << step) : (mag_q >> step);
        rem_left    = rem_q - step;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned below gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        rtype_d   = rtype_q;
        trap_d    = trap_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        pretrap_d = pretrap_q;
        dst_d     = dst_q;
        mag_d     = mag_q;
        rem_d     = rem_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opcode_d  = in_opcode;
                    operand_d = in_operand;
                    pretrap_d = in_pretrap;
                    dst_d     = in_info.dst_type;
                    state_d   = (in_pretrap != TRAP_NONE || !in_info.is_trunc) ? S_EXEC
                                                                              : S_CHECK;
                end
            end

            S_EXEC: begin
                rtype_d = dst_q;
                trap_d  = pretrap_q;
                if (pretrap_q != TRAP_NONE) begin
                    result_d = 64'd0;
                end else begin
                    case (opcode_q)
                        8'hA7, 8'hBC, 8'hBE: result_d = {32'd0, operand_q[31:0]};
                        8'hAC:               result_d = {{32{operand_q[31]}}, operand_q[31:0]};
                        8'hAD:               result_d = {32'd0, operand_q[31:0]};
                        default:             result_d = operand_q;
                    endcase
                end
                state_d = S_DONE;
            end

            S_CHECK: begin
                rtype_d = dst_q;
                if (is_nan) begin
                    result_d = 64'd0;
                    trap_d   = TRAP_INVALID_CONVERSION;
                    state_d  = S_DONE;
                end else if (is_inf || (!is_small && is_ovf)) begin
                    result_d = 64'd0;
                    trap_d   = TRAP_INTEGER_OVERFLOW;
                    state_d  = S_DONE;
                end else if (is_small) begin
                    result_d = 64'd0;
                    trap_d   = TRAP_NONE;
                    state_d  = S_DONE;
                end else if (shift_cnt == 7'd0) begin
                    result_d = finalize(sig, f_sign, dst64);
                    trap_d   = TRAP_NONE;
                    state_d  = S_DONE;
                end else begin
                    mag_d   = sig;
                    rem_d   = shift_cnt;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                mag_d = mag_shifted;
                rem_d = rem_left;
                if (rem_left == 7'd0) begin
                    result_d = finalize(mag_shifted, f_sign, dst64);
                    trap_d   = TRAP_NONE;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= 64'd0;
            rtype_q  <= T_I32;
            trap_q   <= TRAP_NONE;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rtype_q  <= rtype_d;
            trap_q   <= trap_d;
        end
    end

    // NOTE: the working datapath is deliberately left out of reset; it is
    // always written at accept or in CHECK before anything reads it.
    always_ff @(posedge clk) begin
        opcode_q  <= opcode_d;
        operand_q <= operand_d;
        pretrap_q <= pretrap_d;
        dst_q     <= dst_d;
        mag_q     <= mag_d;
        rem_q     <= rem_d;
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign result_type = rtype_q;
    assign trap        = trap_q;

endmodule
